// File: rtl/prim_alert_ping_sched_pkg.sv
// rtl/prim_alert_ping_sched_pkg.sv - shared types and constants for the alert ping scheduler
// Holds the scheduler state encoding, the jitter LFSR constants and the clamp-to-one helper.
package prim_alert_ping_sched_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StPing = 2'd2
   } state_e;

   localparam logic [15:0] LfsrSeed = 16'hACE1;
   localparam logic [15:0] LfsrTaps = 16'hB400;
   localparam logic [15:0] LfsrMask = 16'h000F;

   // A programmed count of zero behaves as one so the scheduler never stalls.
   function automatic logic [31:0] max1(input logic [31:0] v);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

endpackage

// File: rtl/prim_alert_ping_sched_arb.sv
// rtl/prim_alert_ping_sched_arb.sv - combinational round-robin next-enabled-channel finder
// Searches strictly after idx with wrap-around; idx itself is the last candidate.
module prim_alert_ping_sched_arb #(
   parameter int NAlerts = 4,
   parameter int IdxW    = (NAlerts > 1) ? $clog2(NAlerts) : 1
) (
   input  logic [NAlerts-1:0] alert_en,
   input  logic [IdxW-1:0]    idx,
   output logic [IdxW-1:0]    next_idx,
   output logic               valid
);

   int cand;

   // Walk from the farthest offset down so the nearest enabled channel wins.
   always_comb begin
      next_idx = idx;
      valid    = 1'b0;
      cand     = 0;
      for (int k = NAlerts; k >= 1; k--) begin
         cand = (int'(idx) + k) % NAlerts;
         if (alert_en[cand]) begin
            next_idx = IdxW'(cand);
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prim_alert_ping_sched.sv
// rtl/prim_alert_ping_sched.sv - round-robin ping scheduler for a bank of alert receivers
// Define PRIM_ALERT_PING_SCHED_JITTER_EN to add 0..15 cycles of LFSR jitter to each wait.
module prim_alert_ping_sched
   import prim_alert_ping_sched_pkg::*;
#(
   parameter int NAlerts = 4,
   parameter int TimerW  = 16,
   parameter int IdxW    = (NAlerts > 1) ? $clog2(NAlerts) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic [NAlerts-1:0] alert_en_i,
   input  logic [TimerW-1:0]  wait_cyc_i,
   input  logic [TimerW-1:0]  timeout_cyc_i,
   input  logic [NAlerts-1:0] ping_ok_i,
   output logic [NAlerts-1:0] ping_en_o,
   output logic               ping_timeout_o,
   output logic [IdxW-1:0]    timeout_idx_o,
   output logic               busy_o
);

   localparam int WaitW = TimerW + 1;

   state_e             state_q, state_d;
   logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d, wait_load;
   logic [TimerW-1:0]  tmo_cnt_q, tmo_cnt_d, tmo_load;
   logic [IdxW-1:0]    idx_q, idx_d, arb_idx;
   logic [IdxW-1:0]    tmo_idx_q, tmo_idx_d;
   logic [NAlerts-1:0] ping_en_q, ping_en_d;
   logic               tmo_pulse_q, tmo_pulse_d;
   logic               arb_valid;
   logic               ok_hit;

   prim_alert_ping_sched_arb #(
      .NAlerts (NAlerts),
      .IdxW    (IdxW)
   ) u_arb (
      .alert_en (alert_en_i),
      .idx      (idx_q),
      .next_idx (arb_idx),
      .valid    (arb_valid)
   );

   assign tmo_load = TimerW'(max1(32'(timeout_cyc_i)));
   assign ok_hit   = ping_ok_i[idx_q];

`ifdef PRIM_ALERT_PING_SCHED_JITTER_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= LfsrSeed;
      end else if (state_q != StIdle) begin
         lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
      end
   end

   // The extra counter bit absorbs the jitter so a full-scale wait cannot wrap.
   assign wait_load = WaitW'(max1(32'(wait_cyc_i))) + WaitW'(lfsr_q & LfsrMask);
`else
   assign wait_load = WaitW'(max1(32'(wait_cyc_i)));
`endif

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = (wait_cnt_q != '0) ? wait_cnt_q - WaitW'(1) : '0;
      tmo_cnt_d   = (tmo_cnt_q != '0) ? tmo_cnt_q - TimerW'(1) : '0;
      idx_d       = idx_q;
      ping_en_d   = ping_en_q;
      tmo_pulse_d = 1'b0;
      tmo_idx_d   = tmo_idx_q;

      unique case (state_q)
         StIdle: begin
            if (en_i) begin
               state_d    = StWait;
               wait_cnt_d = wait_load;
            end
         end
         StWait: begin
            if (!en_i) begin
               state_d = StIdle;
            end else if (wait_cnt_q <= WaitW'(1)) begin
               if (arb_valid) begin
                  state_d   = StPing;
                  idx_d     = arb_idx;
                  tmo_cnt_d = tmo_load;
                  ping_en_d = NAlerts'(1) << arb_idx;
               end else begin
                  wait_cnt_d = wait_load;
               end
            end
         end
         StPing: begin
            // Enable changes are deferred to ping completion so the receiver protocol holds.
            if (ok_hit || tmo_cnt_q <= TimerW'(1)) begin
               ping_en_d  = '0;
               wait_cnt_d = wait_load;
               state_d    = en_i ? StWait : StIdle;
               if (!ok_hit) begin
                  tmo_pulse_d = 1'b1;
                  tmo_idx_d   = idx_q;
               end
            end
         end
         default: begin
            state_d   = StIdle;
            ping_en_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         wait_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
         idx_q       <= IdxW'(NAlerts - 1);
         ping_en_q   <= '0;
         tmo_pulse_q <= 1'b0;
         tmo_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         idx_q       <= idx_d;
         ping_en_q   <= ping_en_d;
         tmo_pulse_q <= tmo_pulse_d;
         tmo_idx_q   <= tmo_idx_d;
      end
   end

   assign ping_en_o      = ping_en_q;
   assign ping_timeout_o = tmo_pulse_q;
   assign timeout_idx_o  = tmo_idx_q;
   assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_prim_alert_ping_sched.sv
// tb/tb_prim_alert_ping_sched.sv - self-checking bench for the alert ping scheduler
// Deadline-based reference model plus directed scenarios with literal expectations.
module tb_prim_alert_ping_sched;

   localparam int NAlerts = 4;
   localparam int TimerW  = 16;
   localparam int IdxW    = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               en = 1'b0;
   logic [NAlerts-1:0] alert_en = 4'hF;
   logic [TimerW-1:0]  wait_cyc = 16'd5;
   logic [TimerW-1:0]  timeout_cyc = 16'd10;
   logic [NAlerts-1:0] ping_ok = '0;
   logic [NAlerts-1:0] ping_en;
   logic               ping_timeout;
   logic [IdxW-1:0]    timeout_idx;
   logic               busy;

   prim_alert_ping_sched #(
      .NAlerts (NAlerts),
      .TimerW  (TimerW)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .en_i           (en),
      .alert_en_i     (alert_en),
      .wait_cyc_i     (wait_cyc),
      .timeout_cyc_i  (timeout_cyc),
      .ping_ok_i      (ping_ok),
      .ping_en_o      (ping_en),
      .ping_timeout_o (ping_timeout),
      .timeout_idx_o  (timeout_idx),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference model: modes 0=idle 1=waiting 2=pinging, deadlines as absolute cycle numbers.
   int cyc = 0;
   int m_mode, m_ch, m_last, m_sel_at, m_end_at, m_tmo_pulse, m_tmo_idx;
   logic [15:0] m_lfsr;

   task automatic model_reset();
      m_mode      = 0;
      m_ch        = 0;
      m_last      = NAlerts - 1;
      m_sel_at    = 0;
      m_end_at    = 0;
      m_tmo_pulse = 0;
      m_tmo_idx   = 0;
      m_lfsr      = 16'hACE1;
   endtask

   function automatic int wait_len();
      int w;
      w = (wait_cyc == 0) ? 1 : int'(wait_cyc);
`ifdef PRIM_ALERT_PING_SCHED_JITTER_EN
      w += int'(m_lfsr & 16'h000F);
`endif
      return w;
   endfunction

   task automatic model_step();
      int prev, w, t, found;
      prev = m_mode;
      w = wait_len();
      t = (timeout_cyc == 0) ? 1 : int'(timeout_cyc);
      m_tmo_pulse = 0;
      case (m_mode)
         0: if (en) begin
            m_mode = 1;
            m_sel_at = cyc + w;
         end
         1: if (!en) begin
            m_mode = 0;
         end else if (cyc == m_sel_at) begin
            found = -1;
            for (int k = 1; k <= NAlerts; k++)
               if (found < 0 && alert_en[(m_last + k) % NAlerts]) found = (m_last + k) % NAlerts;
            if (found >= 0) begin
               m_mode = 2;
               m_ch = found;
               m_last = found;
               m_end_at = cyc + t;
            end else begin
               m_sel_at = cyc + w;
            end
         end
         default: if (ping_ok[m_ch] || cyc == m_end_at) begin
            if (!ping_ok[m_ch]) begin
               m_tmo_pulse = 1;
               m_tmo_idx = m_ch;
            end
            m_mode = en ? 1 : 0;
            m_sel_at = cyc + w;
         end
      endcase
      if (prev != 0) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) model_reset();
         else model_step();
         @(negedge clk);
         if (!rst_n) model_reset();
         check("ping_en", int'(ping_en), (m_mode == 2) ? (1 << m_ch) : 0);
         check("busy", int'(busy), int'(m_mode != 0));
         check("ping_timeout", int'(ping_timeout), m_tmo_pulse);
         check("timeout_idx", int'(timeout_idx), m_tmo_idx);
         check("onehot0", int'($onehot0(ping_en)), 1);
      end
   end

   // Receiver behaviour and ping history recorder.
   int ok_at[NAlerts];
   int hi_cnt[NAlerts];
   int last_len[NAlerts];
   int fall_cnt[NAlerts];
   bit noise = 1'b0;
   int last_fall = -1;
   int tmo_count = 0;
   int rise_ch[$];
   int rise_gap[$];

   initial begin
      for (int c = 0; c < NAlerts; c++) begin
         ok_at[c] = 4;
         hi_cnt[c] = 0;
         last_len[c] = 0;
         fall_cnt[c] = 0;
      end
      forever begin
         @(negedge clk);
         if (ping_timeout) tmo_count++;
         for (int c = 0; c < NAlerts; c++) begin
            if (ping_en[c]) begin
               if (hi_cnt[c] == 0) begin
                  rise_ch.push_back(c);
                  rise_gap.push_back((last_fall < 0) ? -1 : cyc - last_fall);
               end
               hi_cnt[c]++;
            end else if (hi_cnt[c] != 0) begin
               last_len[c] = hi_cnt[c];
               fall_cnt[c]++;
               last_fall = cyc;
               hi_cnt[c] = 0;
            end
            ping_ok[c] = (ping_en[c] && hi_cnt[c] == ok_at[c]) || (noise && !ping_en[c]);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_rises(input int n, input int budget, input string name);
      for (int i = 0; i < budget && rise_ch.size() < n; i++) tick();
      check({"bound_", name}, int'(rise_ch.size() >= n), 1);
   endtask

   task automatic clear_hist();
      rise_ch.delete();
      rise_gap.delete();
      last_fall = -1;
   endtask

   initial begin
      int exp_seq[5];
      int base, ch;
      exp_seq = '{0, 1, 2, 3, 0};

      // Reset state
      run(3);
      check("reset_ping_en", int'(ping_en), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_timeout", int'(ping_timeout), 0);
      check("reset_timeout_idx", int'(timeout_idx), 0);
      rst_n = 1'b1;
      tick();

      // Round robin over all channels
      clear_hist();
      tmo_count = 0;
      en = 1'b1;
      wait_rises(5, 300, "rr");
      for (int i = 0; i < 5 && i < rise_ch.size(); i++) check("rr_order", rise_ch[i], exp_seq[i]);
      for (int i = 1; i < 5 && i < rise_gap.size(); i++) begin
`ifdef PRIM_ALERT_PING_SCHED_JITTER_EN
         check("rr_gap_range", int'(rise_gap[i] >= 5 && rise_gap[i] <= 20), 1);
`else
         check("rr_gap", rise_gap[i], 5);
`endif
      end
      check("rr_no_timeout", tmo_count, 0);

      // Sparse enable mask
      alert_en = 4'b1010;
      clear_hist();
      run(100);
      check("mask_rises", int'(rise_ch.size() >= 4), 1);
      for (int i = 0; i < rise_ch.size(); i++) begin
         check("mask_chan", int'(rise_ch[i] == 1 || rise_ch[i] == 3), 1);
         if (i > 0) check("mask_alternate", int'(rise_ch[i] != rise_ch[i-1]), 1);
      end

      // Channel 2 never answers
      alert_en = 4'hF;
      ok_at[2] = -1;
      tmo_count = 0;
      for (int i = 0; i < 300 && tmo_count == 0; i++) tick();
      check("tmo_seen", tmo_count, 1);
      check("tmo_len", last_len[2], 10);
      check("tmo_idx", int'(timeout_idx), 2);
      ok_at[2] = 4;
      clear_hist();
      wait_rises(1, 100, "tmo_next");
      if (rise_ch.size() > 0) check("tmo_next_chan", rise_ch[0], 3);
      check("tmo_once", tmo_count, 1);

      // Ok arrives in the cycle the timeout expires
      ok_at[1] = 10;
      tmo_count = 0;
      base = fall_cnt[1];
      for (int i = 0; i < 300 && fall_cnt[1] == base; i++) tick();
      check("race_len", last_len[1], 10);
      check("race_no_timeout", tmo_count, 0);
      ok_at[1] = 4;

      // Disable two cycles into a ping
      clear_hist();
      wait_rises(1, 100, "dis");
      ch = (rise_ch.size() > 0) ? rise_ch[0] : 0;
      run(2);
      en = 1'b0;
      for (int i = 0; i < 50 && ping_en != 0; i++) tick();
      tick();
      check("dis_len", last_len[ch], 4);
      check("dis_busy", int'(busy), 0);
      run(20);
      check("dis_no_more", rise_ch.size(), 1);

      // No channel enabled
      alert_en = 4'h0;
      en = 1'b1;
      clear_hist();
      run(50);
      check("none_rises", rise_ch.size(), 0);
      check("none_busy", int'(busy), 1);

      // Stray oks, then asynchronous reset mid-ping
      alert_en = 4'hF;
      noise = 1'b1;
      clear_hist();
      wait_rises(3, 200, "noise");
      noise = 1'b0;
      run(2);
      check("pre_reset_ping", int'(ping_en != 0), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_ping_en", int'(ping_en), 0);
      check("async_reset_busy", int'(busy), 0);
      run(3);
      rst_n = 1'b1;
      clear_hist();
      wait_rises(1, 100, "post_reset");
      if (rise_ch.size() > 0) check("post_reset_chan", rise_ch[0], 0);
      run(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/prim_alert_ping_sched.md
Name: prim_alert_ping_sched

Overview:
- Ping scheduler for a bank of alert receivers.
- Periodically selects one enabled alert channel in round-robin order and raises that channel's ping enable. Holds it until the receiver reports ping ok, or until a timeout expires.
- Sits between the alert handler configuration/escalation logic and the prim_alert_receiver instances.
- Guarantees the ping-enable protocol those receivers require: held until ok, dropped the cycle after ok.

Parameters:
- NAlerts, 4, number of alert receiver channels pinged (1..32).
- TimerW, 16, width of wait/timeout counters and their configuration inputs.
- IdxW, $clog2(NAlerts) (min 1), derived width of channel index outputs.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  scheduler enable (level).
- alert_en_i  in  NAlerts  per-channel enable; disabled channels are never pinged.
- wait_cyc_i  in  TimerW  cycles between end of one ping and start of next.
- timeout_cyc_i  in  TimerW  max cycles ping_en may stay high without ping ok.
- ping_ok_i  in  NAlerts  ping ok pulses from receivers.
- ping_en_o  out  NAlerts  one-hot-or-zero ping enables to receivers.
- ping_timeout_o  out  1  single-cycle pulse on timeout.
- timeout_idx_o  out  IdxW  channel index of most recent timeout (held).
- busy_o  out  1  high while not in Idle.

Behaviour:
- Reset values: all outputs 0; idx_q = NAlerts-1, so the first scan starts at channel 0; counters 0; state Idle.
- States and transitions:
  - Idle -> Wait: when en_i=1. Load wait counter with max(wait_cyc_i,1).
  - Wait: decrement each cycle. At count 1, select the next enabled channel strictly after idx_q, with wrap-around, via the arbiter.
    - Enabled channel found: go to Ping next cycle. Latch idx. Load timeout counter with max(timeout_cyc_i,1).
    - No channel enabled: reload wait counter and stay in Wait.
    - en_i=0 in Wait: go to Idle immediately.
  - Ping: ping_en_o[idx_q]=1, registered, all other bits 0.
    - ping_ok_i[idx_q]=1: ping_en_o drops the next cycle. Go to Wait with reloaded wait counter.
    - Else counter reaches 1: pulse ping_timeout_o for one cycle, update timeout_idx_o=idx_q, drop ping_en_o, go to Wait.
    - ok and timeout in the same cycle: ok wins, no timeout pulse.
- Ping latency: ping_en_o rises exactly wait_cyc_i cycles after the ok/timeout cycle. A value of 0 is treated as 1.
- ping_ok_i on a non-selected channel, or outside Ping: ignored.
- en_i deasserted in Ping: the ping completes (ok or timeout), then go to Idle instead of Wait. ping_en_o is never dropped early.
- alert_en_i[idx_q] cleared during Ping: the ping still completes normally. The enable is only sampled at selection time.
- Config inputs are sampled only at counter load. Mid-count changes have no effect.
- Counters saturate at 0, never wrap.
- Asynchronous reset mid-Ping: ping_en_o goes to 0 immediately.
- Invariant: $onehot0(ping_en_o) in all states.

Optional Feature:
- Macro: PRIM_ALERT_PING_SCHED_JITTER_EN.
- Defined:
  - A 16-bit Galois LFSR (seed 16'hACE1, taps 16'hB400) advances every cycle when not Idle.
  - Wait load = max(wait_cyc_i,1) + (lfsr & 16'h000F), zero-extended to TimerW+1 bits, so there is no overflow.
- Undefined: no LFSR; wait load exactly as in Behaviour. All other timing is identical.

Decomposition:
- Package prim_alert_ping_sched_pkg holds:
  - state enum (Idle, Wait, Ping), 2-bit encoding;
  - LFSR seed/taps/mask localparams;
  - function max1(TimerW) for clamping to 1.
- One sub-module, prim_alert_ping_sched_arb:
  - combinational next-enabled finder.
  - Inputs: alert_en, current idx.
  - Outputs: next idx, valid.
  - Round-robin with wrap.
  - Unit-testable standalone.

Test Plan:
- NAlerts=4, all enabled, wait=5, timeout=10, each receiver returns ok 3 cycles after ping_en rises -> ping_en_o sequence 0001,0010,0100,1000,0001; rises 5 cycles after each ok; no timeout.
- alert_en_i=4'b1010 -> only channels 1 and 3 pinged, alternating; channels 0 and 2 never high.
- Channel 2 never returns ok, timeout=10 -> ping_en_o[2] high exactly 10 cycles; ping_timeout_o pulses once; timeout_idx_o=2; scan continues with channel 3.
- ok on channel 1 in the same cycle the timeout expires -> no timeout pulse; ping_en_o[1] drops next cycle.
- en_i dropped 2 cycles into a ping -> ping_en_o holds until ok, then busy_o=0, Idle. alert_en_i=0 -> never pings, stays in Wait.
- Async reset asserted mid-Ping -> ping_en_o=0 immediately. After release with en_i=1, the first ping is on channel 0. Jitter build: wait in [5,20].
